key_command_unit: RTL and testbench
===================================

# key_command_unit

Translates raw PS/2 keyboard state into single-cycle game commands for `game_play`. It sits between `KeyboardDecoder`, which supplies `key_down`, `last_change` and `key_valid`, and the game state machine. Responsibilities:
- Filter make events down to the game's key set: N, B, R, 1–3, arrows, shift.
- Encode each accepted key into a 4-bit command strobe.
- Generate auto-repeat for a held arrow key.
- Report shift status.

## Interface
- `REPEAT_DELAY`, default 25_000_000: cycles from an arrow press to the first repeat; must be ≥ 2.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeats; must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset; one clock domain only.
- `key_down`  in  512  held-key bitmap from `KeyboardDecoder`, indexed by 9-bit code (bit 8 = E0 extended).
- `last_change`  in  9  code of the most recent make/break event.
- `key_valid`  in  1  single-cycle strobe, asserted when `last_change` is updated.
- `cmd_valid`  out  1  single-cycle command strobe.
- `cmd`  out  4  command code; holds its value between strobes.
- `cmd_shift`  out  1  `shift_held` sampled in the same cycle as the strobe.
- `shift_held`  out  1  registered: `key_down[9'h012] | key_down[9'h059]`.

## Operation
- A make event is `key_valid && key_down[last_change]`. A break event (`key_valid` with the bit clear) never produces a command.
- Code map, make event to `cmd`:
  - arrows: up `9'h175` → 1, down `9'h172` → 2, left `9'h16B` → 3, right `9'h174` → 4
  - N `9'h031` → 5, B `9'h032` → 6, R `9'h02D` → 7
  - 1 `9'h016` → 8, 2 `9'h01E` → 9, 3 `9'h026` → 10
- All other codes are ignored, including shift, which only drives `shift_held`. Codes 0 and 11–15 are never emitted.
- Repeat FSM states:
  - IDLE: no repeat active.
  - DELAY: waiting for the first repeat.
  - REPEAT: periodic repeat.
- Registers: `rep_key` (9 bits) holds the arrow being repeated; `rep_cnt` (32 bits) is the repeat counter.
- Any state, arrow make event:
  - emit the arrow's command;
  - `rep_key` ← `last_change`, `rep_cnt` ← 0, state ← DELAY.
  - This includes a different arrow pressed while one is already repeating: the newest arrow wins.
- DELAY:
  - if `key_down[rep_key]` = 0: state ← IDLE, no emission;
  - else if `rep_cnt` = `REPEAT_DELAY`−1: emit `rep_key`'s command, `rep_cnt` ← 0, state ← REPEAT;
  - else `rep_cnt` += 1.
- REPEAT: same as DELAY, with `REPEAT_PERIOD`−1 as the terminal count and the state remaining REPEAT.
- The held-key check uses `key_down` directly, so a break of `rep_key` stops repeat even if that break strobe coincides with nothing else.
- Non-arrow make event, any state: emit the command. FSM state and `rep_key` are unchanged.
- Collision: a non-arrow make event and a repeat terminal count in the same cycle:
  - the make event's command is emitted and the repeat tick is dropped;
  - `rep_cnt` ← 0 and the state still advances DELAY→REPEAT as if the tick had fired.
- At most one `cmd_valid` per cycle. Exactly one emission per accepted make event, except when an arrow make coincides with a repeat terminal count: the new arrow is emitted, the old tick is dropped.

## Timing
- Reset values: `cmd_valid` 0, `cmd` 0, `cmd_shift` 0, `shift_held` 0, state IDLE, `rep_key` 0, `rep_cnt` 0.
- Reset asserted mid-repeat aborts the repeat immediately; no strobe is emitted in the reset cycle or the cycle after it.
- Latency:
  - make event at cycle t → `cmd_valid` high at t+1 for exactly one cycle;
  - `shift_held` follows `key_down` with 1 cycle latency.
- Repeat timing for an arrow make event at cycle t, held continuously:
  - initial strobe at t+1;
  - first repeat strobe at t+1+`REPEAT_DELAY`;
  - subsequent strobes every `REPEAT_PERIOD` cycles.
- Release: if `key_down[rep_key]` falls at cycle u, no repeat strobe occurs at u+1 or later.
- `key_valid` held high on consecutive cycles is treated as consecutive events, each evaluated independently.

## Test plan
- **Reset and single keys:** reset 2 cycles, then make N (`last_change` `9'h031`, `key_down` bit set, `key_valid` 1 cycle) → one `cmd_valid` with `cmd`=5, `cmd_shift`=0; break N → no strobe.
- **Auto-repeat:** `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4; hold up (`9'h175`) for 30 cycles → strobes with `cmd`=1 at t+1, t+9, t+13, t+17, t+21, t+25, t+29; release → no further strobes.
- **Arrow switch:** while left is repeating, make right → immediate strobe `cmd`=4; the next repeat is 8 cycles later with `cmd`=4; left strobes never reappear.
- **Shift:** hold left shift (`9'h012`), make 2 → `cmd`=9, `cmd_shift`=1; `shift_held` is 1 one cycle after the bit is set.
- **Collision:** with `REPEAT_PERIOD`=4, a make of R on the repeat terminal-count cycle → single strobe `cmd`=7; the next arrow strobe comes 4 cycles later.
- **Reset and ignored codes:** assert `rst` during REPEAT → no strobes afterward while the arrow stays held; make of unmapped code `9'h01C` → no strobe.

Source files
------------

// File: rtl/key_command_unit.sv
// Game command front end: filters keyboard make events into 4-bit command strobes,
// auto-repeats a held arrow key and reports shift status.
module key_command_unit #(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output logic         cmd_valid,
  output logic [3:0]   cmd,
  output logic         cmd_shift,
  output logic         shift_held
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [31:0] C_DELAY_TC  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] C_PERIOD_TC = 32'(REPEAT_PERIOD - 1);

  function automatic logic [3:0] f_map(input logic [8:0] code);
    case (code)
      9'h175:  f_map = 4'd1;
      9'h172:  f_map = 4'd2;
      9'h16B:  f_map = 4'd3;
      9'h174:  f_map = 4'd4;
      9'h031:  f_map = 4'd5;
      9'h032:  f_map = 4'd6;
      9'h02D:  f_map = 4'd7;
      9'h016:  f_map = 4'd8;
      9'h01E:  f_map = 4'd9;
      9'h026:  f_map = 4'd10;
      default: f_map = 4'd0;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [8:0]  r_rep_key;
  logic [31:0] r_rep_cnt;
  logic        r_cmd_valid;
  logic [3:0]  r_cmd;
  logic        r_cmd_shift;
  logic        r_shift_held;

  logic        w_make;
  logic [3:0]  w_make_cmd;
  logic        w_make_arrow;
  logic        w_rep_held;
  logic        w_tc;
  logic        w_shift;
  logic [1:0]  w_state_nx;
  logic [8:0]  w_key_nx;
  logic [31:0] w_cnt_nx;
  logic        w_tick;
  logic        w_emit;
  logic [3:0]  w_emit_cmd;

  assign w_make       = key_valid & key_down[last_change];
  assign w_make_cmd   = w_make ? f_map(last_change) : 4'd0;
  assign w_make_arrow = (w_make_cmd != 4'd0) && (w_make_cmd <= 4'd4);
  assign w_rep_held   = key_down[r_rep_key];
  assign w_tc         = ((r_state == S_DELAY)  && (r_rep_cnt == C_DELAY_TC)) ||
                        ((r_state == S_REPEAT) && (r_rep_cnt == C_PERIOD_TC));
  assign w_shift      = key_down[9'h012] | key_down[9'h059];

  // Repeat timing keeps advancing under a non-arrow make; only the emitted code
  // is arbitrated, so a colliding tick is dropped but still resets the period.
  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_rep_key;
    w_cnt_nx   = r_rep_cnt;
    w_tick     = 1'b0;
    if (w_make_arrow) begin
      w_state_nx = S_DELAY;
      w_key_nx   = last_change;
      w_cnt_nx   = '0;
    end else if (r_state != S_IDLE) begin
      if (!w_rep_held) begin
        w_state_nx = S_IDLE;
      end else if (w_tc) begin
        w_state_nx = S_REPEAT;
        w_cnt_nx   = '0;
        w_tick     = 1'b1;
      end else begin
        w_cnt_nx = r_rep_cnt + 32'd1;
      end
    end
    w_emit     = (w_make_cmd != 4'd0) | w_tick;
    w_emit_cmd = (w_make_cmd != 4'd0) ? w_make_cmd : f_map(r_rep_key);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rep_key    <= '0;
      r_rep_cnt    <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd        <= '0;
      r_cmd_shift  <= 1'b0;
      r_shift_held <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_rep_key    <= w_key_nx;
      r_rep_cnt    <= w_cnt_nx;
      r_cmd_valid  <= w_emit;
      r_shift_held <= w_shift;
      if (w_emit) begin
        r_cmd       <= w_emit_cmd;
        r_cmd_shift <= w_shift;
      end
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd        = r_cmd;
  assign cmd_shift  = r_cmd_shift;
  assign shift_held = r_shift_held;

endmodule

// File: tb/tb_key_command_unit.sv
// Bench for key_command_unit: directed scenarios plus random key traffic, all
// checked against a timestamp-based model of the command/repeat rules.
module tb_key_command_unit;

  localparam int unsigned RD = 8;
  localparam int unsigned RP = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic         cmd_valid;
  logic [3:0]   cmd;
  logic         cmd_shift;
  logic         shift_held;

  int unsigned checks = 0;
  int unsigned errors = 0;

  key_command_unit #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change),
    .key_valid(key_valid), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_shift(cmd_shift), .shift_held(shift_held)
  );

  always #5 clk = ~clk;

  logic [8:0] map_codes [10] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h031,
                                 9'h032, 9'h02D, 9'h016, 9'h01E, 9'h026};
  logic [8:0] rnd_codes [14] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h031, 9'h032,
                                 9'h02D, 9'h016, 9'h01E, 9'h026, 9'h012, 9'h059,
                                 9'h01C, 9'h15A};

  function automatic int unsigned code_of(input logic [8:0] c);
    for (int i = 0; i < 10; i++) if (map_codes[i] == c) return i + 1;
    return 0;
  endfunction

  // Reference model: repeat is an absolute "next tick" cycle number.
  int unsigned cyc_n = 0;
  bit          m_active = 0;
  logic [8:0]  m_key = '0;
  int unsigned m_next = 0;
  int unsigned m_c;
  bit          m_tick;
  logic        m_valid = 0;
  logic [3:0]  m_cmd = '0;
  logic        m_cshift = 0;
  logic        m_shold = 0;
  logic        m_sh;

  always @(posedge clk) begin
    cyc_n++;
    if (rst) begin
      m_active = 0; m_valid = 0; m_cmd = '0; m_cshift = 0; m_shold = 0;
    end else begin
      m_valid = 0;
      m_tick  = 0;
      m_c = (key_valid && key_down[last_change]) ? code_of(last_change) : 0;
      if (m_c >= 1 && m_c <= 4) begin
        m_active = 1; m_key = last_change; m_next = cyc_n + RD;
      end else if (m_active) begin
        if (!key_down[m_key]) m_active = 0;
        else if (cyc_n == m_next) begin m_tick = 1; m_next = cyc_n + RP; end
      end
      m_sh = key_down[9'h012] | key_down[9'h059];
      if (m_c != 0) begin m_valid = 1; m_cmd = 4'(m_c); end
      else if (m_tick) begin m_valid = 1; m_cmd = 4'(code_of(m_key)); end
      if (m_valid) m_cshift = m_sh;
      m_shold = m_sh;
    end
  end

  task automatic drive_key(input logic [8:0] code, input logic down);
    key_down[code] = down;
    last_change    = code;
    key_valid      = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0b exp 0", cmd_valid); end
    checks++;
    if (cmd !== 4'd0) begin errors++; $display("FAIL reset_cmd: got %0d exp 0", cmd); end
    checks++;
    if (cmd_shift !== 1'b0) begin errors++; $display("FAIL reset_cmd_shift: got %0b exp 0", cmd_shift); end
    checks++;
    if (shift_held !== 1'b0) begin errors++; $display("FAIL reset_shift_held: got %0b exp 0", shift_held); end
    rst = 1'b0;
  endtask

  task automatic test_single_keys();
    drive_key(9'h031, 1'b1);
    next_cycle();
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 4'd5 || cmd_shift !== 1'b0) begin
      errors++; $display("FAIL make_N: got v=%0b cmd=%0d sh=%0b exp v=1 cmd=5 sh=0", cmd_valid, cmd, cmd_shift);
    end
    next_cycle();
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL make_N_one_pulse: got v=%0b exp 0", cmd_valid); end
    drive_key(9'h031, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if (cmd_valid !== 1'b0 || cmd !== 4'd5) begin
        errors++; $display("FAIL break_N: got v=%0b cmd=%0d exp v=0 cmd=5", cmd_valid, cmd);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [39:0] obs, exp_mask;
    obs = '0;
    exp_mask = '0;
    exp_mask[0] = 1; exp_mask[8] = 1; exp_mask[12] = 1; exp_mask[16] = 1;
    exp_mask[20] = 1; exp_mask[24] = 1; exp_mask[28] = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 0)  drive_key(9'h175, 1'b1);
      if (i == 30) drive_key(9'h175, 1'b0);
      next_cycle();
      obs[i] = cmd_valid;
      checks++;
      if (cmd_valid !== m_valid || cmd !== m_cmd || cmd_shift !== m_cshift || shift_held !== m_shold) begin
        errors++; $display("FAIL repeat_model i=%0d: got v=%0b cmd=%0d exp v=%0b cmd=%0d", i, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (cmd_valid === 1'b1) begin
        checks++;
        if (cmd !== 4'd1) begin errors++; $display("FAIL repeat_cmd i=%0d: got %0d exp 1", i, cmd); end
      end
    end
    checks++;
    if (obs !== exp_mask) begin errors++; $display("FAIL repeat_timing: got %h exp %h", obs, exp_mask); end
  endtask

  task automatic test_arrow_switch();
    int unsigned old_after = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0)  drive_key(9'h16B, 1'b1);
      if (i == 10) drive_key(9'h174, 1'b1);
      if (i == 22) begin key_down[9'h16B] = 1'b0; end
      if (i == 24) drive_key(9'h174, 1'b0);
      next_cycle();
      checks++;
      if (cmd_valid !== m_valid || cmd !== m_cmd || cmd_shift !== m_cshift || shift_held !== m_shold) begin
        errors++; $display("FAIL switch_model i=%0d: got v=%0b cmd=%0d exp v=%0b cmd=%0d", i, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (i >= 10 && cmd_valid === 1'b1 && cmd === 4'd3) old_after++;
      if (i == 10 || i == 18 || i == 22) begin
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 4'd4) begin
          errors++; $display("FAIL switch_right i=%0d: got v=%0b cmd=%0d exp v=1 cmd=4", i, cmd_valid, cmd);
        end
      end
    end
    checks++;
    if (old_after != 0) begin errors++; $display("FAIL switch_old_arrow: got %0d left strobes exp 0", old_after); end
  endtask

  task automatic test_shift();
    drive_key(9'h012, 1'b1);
    next_cycle();
    checks++;
    if (shift_held !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL shift_held_rise: got held=%0b v=%0b exp held=1 v=0", shift_held, cmd_valid);
    end
    drive_key(9'h01E, 1'b1);
    next_cycle();
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 4'd9 || cmd_shift !== 1'b1) begin
      errors++; $display("FAIL shift_make_2: got v=%0b cmd=%0d sh=%0b exp v=1 cmd=9 sh=1", cmd_valid, cmd, cmd_shift);
    end
    drive_key(9'h01E, 1'b0);
    next_cycle();
    drive_key(9'h012, 1'b0);
    next_cycle();
    checks++;
    if (shift_held !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL shift_held_fall: got held=%0b v=%0b exp held=0 v=0", shift_held, cmd_valid);
    end
  endtask

  task automatic test_collision();
    int unsigned n = 0;
    for (int i = 0; i < 28; i++) begin
      if (i == 0)  drive_key(9'h175, 1'b1);
      if (i == 12) drive_key(9'h02D, 1'b1);
      if (i == 14) drive_key(9'h02D, 1'b0);
      if (i == 22) drive_key(9'h175, 1'b0);
      next_cycle();
      if (cmd_valid === 1'b1) n++;
      checks++;
      if (cmd_valid !== m_valid || cmd !== m_cmd || cmd_shift !== m_cshift || shift_held !== m_shold) begin
        errors++; $display("FAIL collision_model i=%0d: got v=%0b cmd=%0d exp v=%0b cmd=%0d", i, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (i == 12) begin
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 4'd7) begin
          errors++; $display("FAIL collision_R: got v=%0b cmd=%0d exp v=1 cmd=7", cmd_valid, cmd);
        end
      end
      if (i == 16) begin
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 4'd1) begin
          errors++; $display("FAIL collision_next_tick: got v=%0b cmd=%0d exp v=1 cmd=1", cmd_valid, cmd);
        end
      end
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL collision_count: got %0d exp 5", n); end
  endtask

  task automatic test_reset_mid_repeat();
    int unsigned late = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0)  drive_key(9'h172, 1'b1);
      if (i == 13) rst = 1'b1;
      if (i == 14) rst = 1'b0;
      next_cycle();
      if (i >= 13 && cmd_valid !== 1'b0) late++;
      checks++;
      if (cmd_valid !== m_valid || cmd !== m_cmd || cmd_shift !== m_cshift || shift_held !== m_shold) begin
        errors++; $display("FAIL rstmid_model i=%0d: got v=%0b cmd=%0d exp v=%0b cmd=%0d", i, cmd_valid, cmd, m_valid, m_cmd);
      end
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL rstmid_strobes: got %0d exp 0", late); end
    drive_key(9'h172, 1'b0);
    next_cycle();
  endtask

  task automatic test_ignored_codes();
    drive_key(9'h01C, 1'b1);
    next_cycle();
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ignored_01C: got v=%0b exp 0", cmd_valid); end
    drive_key(9'h059, 1'b1);
    next_cycle();
    checks++;
    if (cmd_valid !== 1'b0 || shift_held !== 1'b1) begin
      errors++; $display("FAIL ignored_rshift: got v=%0b held=%0b exp v=0 held=1", cmd_valid, shift_held);
    end
    drive_key(9'h01C, 1'b0);
    next_cycle();
    drive_key(9'h059, 1'b0);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_c [3] = '{4'd5, 4'd6, 4'd10};
    logic [8:0] codes [3] = '{9'h031, 9'h032, 9'h026};
    for (int i = 0; i < 3; i++) begin
      drive_key(codes[i], 1'b1);
      next_cycle();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== exp_c[i]) begin
        errors++; $display("FAIL back_to_back i=%0d: got v=%0b cmd=%0d exp v=1 cmd=%0d", i, cmd_valid, cmd, exp_c[i]);
      end
    end
    key_down = '0;
    next_cycle();
  endtask

  task automatic test_random();
    int unsigned r;
    logic [8:0] c;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      c = rnd_codes[$urandom_range(0, 13)];
      if (r >= 6 && r < 11) drive_key(c, 1'b1);
      else if (r >= 11 && r < 15) drive_key(c, 1'b0);
      else if (r == 15) begin last_change = c; key_valid = 1'b1; end
      next_cycle();
      checks++;
      if (cmd_valid !== m_valid || cmd !== m_cmd || cmd_shift !== m_cshift || shift_held !== m_shold) begin
        errors++;
        $display("FAIL random_model i=%0d: got v=%0b cmd=%0d sh=%0b held=%0b exp v=%0b cmd=%0d sh=%0b held=%0b",
                 i, cmd_valid, cmd, cmd_shift, shift_held, m_valid, m_cmd, m_cshift, m_shold);
      end
    end
    key_down = '0;
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_keys();
    test_auto_repeat();
    test_arrow_switch();
    test_shift();
    test_collision();
    test_reset_mid_repeat();
    test_ignored_codes();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
